// File: rtl/vga_pkg.sv
// Default 640x480@60 timing constants, counter widths and the per-axis phase type.
// Pure declarations; no latency or flow control.
package vga_pkg;

    localparam int DEF_CLK_DIV  = 2;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;

    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    localparam int DEF_WIN_X0   = 200;
    localparam int DEF_WIN_X1   = 425;
    localparam int DEF_WIN_Y0   = 150;
    localparam int DEF_WIN_Y1   = 375;

    localparam int HC_W = 11;
    localparam int VC_W = 10;

    typedef enum logic [1:0] {
        PH_ACTIVE,
        PH_FP,
        PH_SYNC,
        PH_BP
    } vga_phase_e;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter, ACTIVE/FP/SYNC/BP phase FSM and registered sync.
// Latency: count/sync update on the enabled edge; next-state values exposed for aligned flags. No backpressure.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int W      = HC_W,
    parameter int ACTIVE = DEF_H_ACTIVE,
    parameter int FP     = DEF_H_FP,
    parameter int SYNC   = DEF_H_SYNC,
    parameter int BP     = DEF_H_BP,
    parameter bit POL    = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         adv,
    output logic [W-1:0] count,
    output logic [W-1:0] count_nxt,
    output logic         wrap,
    output logic         act_nxt,
    output logic         sync
);

    localparam logic [W-1:0] A_LAST = W'(ACTIVE - 1);
    localparam logic [W-1:0] F_LAST = W'(ACTIVE + FP - 1);
    localparam logic [W-1:0] S_LAST = W'(ACTIVE + FP + SYNC - 1);
    localparam logic [W-1:0] B_LAST = W'(ACTIVE + FP + SYNC + BP - 1);

    vga_phase_e phase, phase_nxt;

    always_comb begin
        wrap      = adv && (count == B_LAST);
        count_nxt = count;
        phase_nxt = phase;
        if (adv) begin
            count_nxt = wrap ? '0 : count + 1'b1;
            case (phase)
                PH_ACTIVE: if (count == A_LAST) phase_nxt = PH_FP;
                PH_FP:     if (count == F_LAST) phase_nxt = PH_SYNC;
                PH_SYNC:   if (count == S_LAST) phase_nxt = PH_BP;
                PH_BP:     if (count == B_LAST) phase_nxt = PH_ACTIVE;
                default:   phase_nxt = PH_BP;
            endcase
        end
        act_nxt = (phase_nxt == PH_ACTIVE);
    end

    // Reset parks on the last position, which belongs to the back porch.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= B_LAST;
            phase <= PH_BP;
            sync  <= !POL;
        end else begin
            count <= count_nxt;
            phase <= phase_nxt;
            sync  <= (phase_nxt == PH_SYNC) ? POL : !POL;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing with image-window qualifiers; VGA_TEST_PATTERN_EN adds an RGB332 pattern output.
// Latency: all outputs registered from next-state counters (zero skew to hcount/vcount). No backpressure.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int CLK_DIV  = DEF_CLK_DIV,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int WIN_X0   = DEF_WIN_X0,
    parameter int WIN_X1   = DEF_WIN_X1,
    parameter int WIN_Y0   = DEF_WIN_Y0,
    parameter int WIN_Y1   = DEF_WIN_Y1
) (
    input  logic            clk,
    input  logic            rst,
    output logic            pix_tick,
    output logic [HC_W-1:0] hcount,
    output logic [VC_W-1:0] vcount,
    output logic            hsync,
    output logic            vsync,
    output logic            blank_n,
    output logic            line_start,
    output logic            frame_start,
    output logic            win_active,
    output logic            win_first
`ifdef VGA_TEST_PATTERN_EN
    ,
    output logic [7:0]      pattern
`endif
);

    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    if (CLK_DIV < 1) begin : g_bad_div
        $error("vga_timing_gen: CLK_DIV must be >= 1");
    end
    if (H_TOT > (1 << HC_W) || WIN_X0 >= (1 << HC_W) || WIN_X1 >= (1 << HC_W)) begin : g_bad_h
        $error("vga_timing_gen: horizontal parameter exceeds hcount width");
    end
    if (V_TOT > (1 << VC_W) || WIN_Y0 >= (1 << VC_W) || WIN_Y1 >= (1 << VC_W)) begin : g_bad_v
        $error("vga_timing_gen: vertical parameter exceeds vcount width");
    end

    logic [DIV_W-1:0] div;
    logic [HC_W-1:0]  h_nxt;
    logic [VC_W-1:0]  v_nxt;
    logic             h_wrap, v_wrap, h_act_nxt, v_act_nxt;
    logic             win_nxt;

    assign pix_tick = (div == DIV_W'(CLK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst || pix_tick) div <= '0;
        else                 div <= div + 1'b1;
    end

    vga_axis_counter #(
        .W(HC_W), .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(HS_POL)
    ) u_h (
        .clk(clk), .rst(rst), .adv(pix_tick),
        .count(hcount), .count_nxt(h_nxt), .wrap(h_wrap), .act_nxt(h_act_nxt), .sync(hsync)
    );

    vga_axis_counter #(
        .W(VC_W), .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(VS_POL)
    ) u_v (
        .clk(clk), .rst(rst), .adv(h_wrap & pix_tick),
        .count(vcount), .count_nxt(v_nxt), .wrap(v_wrap), .act_nxt(v_act_nxt), .sync(vsync)
    );

    // Window is deliberately not qualified by blanking; it may extend past the active area.
    always_comb begin
        win_nxt = (h_nxt >= HC_W'(WIN_X0)) && (h_nxt <= HC_W'(WIN_X1)) &&
                  (v_nxt >= VC_W'(WIN_Y0)) && (v_nxt <= VC_W'(WIN_Y1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            blank_n     <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            win_active  <= 1'b0;
            win_first   <= 1'b0;
        end else begin
            blank_n     <= h_act_nxt && v_act_nxt;
            line_start  <= (h_nxt == '0);
            frame_start <= (h_nxt == '0) && (v_nxt == '0);
            win_active  <= win_nxt;
            win_first   <= (h_nxt == HC_W'(WIN_X0)) && (v_nxt == VC_W'(WIN_Y0));
        end
    end

`ifdef VGA_TEST_PATTERN_EN
    always_ff @(posedge clk) begin
        if (rst)                        pattern <= 8'h00;
        else if (h_act_nxt && v_act_nxt) pattern <= {h_nxt[9:7], v_nxt[8:6], h_nxt[6:5]};
        else                            pattern <= 8'h00;
    end
`endif

    logic unused_v_wrap;
    assign unused_v_wrap = v_wrap;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default-timing DUT for reset/line checks, a scaled DUT for frame/window checks.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic rst_a, rst_s;
    logic        a_tick, a_hs, a_vs, a_bn, a_ls, a_fs, a_wa, a_wf;
    logic [10:0] a_hc;
    logic [9:0]  a_vc;
    logic        s_tick, s_hs, s_vs, s_bn, s_ls, s_fs, s_wa, s_wf;
    logic [10:0] s_hc;
    logic [9:0]  s_vc;
`ifdef VGA_TEST_PATTERN_EN
    logic [7:0]  a_pat, s_pat, p_pat;
    logic        rst_p;
    logic        p_tick, p_hs, p_vs, p_bn, p_ls, p_fs, p_wa, p_wf;
    logic [10:0] p_hc;
    logic [9:0]  p_vc;
`endif

    vga_timing_gen u_a (
        .clk(clk), .rst(rst_a), .pix_tick(a_tick), .hcount(a_hc), .vcount(a_vc),
        .hsync(a_hs), .vsync(a_vs), .blank_n(a_bn), .line_start(a_ls),
        .frame_start(a_fs), .win_active(a_wa), .win_first(a_wf)
`ifdef VGA_TEST_PATTERN_EN
        , .pattern(a_pat)
`endif
    );

    // Scaled raster: 24x18 total, hsync cols 18..20, vsync rows 14..15 (active high), window 4..9 x 3..7.
    vga_timing_gen #(
        .CLK_DIV(1), .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(2), .HS_POL(1'b0), .VS_POL(1'b1),
        .WIN_X0(4), .WIN_X1(9), .WIN_Y0(3), .WIN_Y1(7)
    ) u_s (
        .clk(clk), .rst(rst_s), .pix_tick(s_tick), .hcount(s_hc), .vcount(s_vc),
        .hsync(s_hs), .vsync(s_vs), .blank_n(s_bn), .line_start(s_ls),
        .frame_start(s_fs), .win_active(s_wa), .win_first(s_wf)
`ifdef VGA_TEST_PATTERN_EN
        , .pattern(s_pat)
`endif
    );

`ifdef VGA_TEST_PATTERN_EN
    vga_timing_gen #(.CLK_DIV(1)) u_p (
        .clk(clk), .rst(rst_p), .pix_tick(p_tick), .hcount(p_hc), .vcount(p_vc),
        .hsync(p_hs), .vsync(p_vs), .blank_n(p_bn), .line_start(p_ls),
        .frame_start(p_fs), .win_active(p_wa), .win_first(p_wf), .pattern(p_pat)
    );
`endif

    task automatic wait_tick_a(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (a_tick === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_a = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (a_hc !== 11'd799) begin bad++; $display("FAIL reset_hcount got=%0d want=799", a_hc); end
        total++; if (a_vc !== 10'd524) begin bad++; $display("FAIL reset_vcount got=%0d want=524", a_vc); end
        total++;
        if ({a_tick, a_hs, a_vs, a_bn, a_ls, a_fs, a_wa, a_wf} !== 8'b0110_0000) begin
            bad++; $display("FAIL reset_flags got=%b want=01100000", {a_tick, a_hs, a_vs, a_bn, a_ls, a_fs, a_wa, a_wf});
        end
        rst_a = 1'b0;
        @(negedge clk);
        total++; if ({a_tick, a_hc} !== {1'b1, 11'd799}) begin bad++; $display("FAIL first_tick got tick=%b h=%0d want tick=1 h=799", a_tick, a_hc); end
        @(negedge clk);
        total++; if ({a_hc, a_vc} !== 21'd0) begin bad++; $display("FAIL origin got h=%0d v=%0d want 0,0", a_hc, a_vc); end
        total++;
        if ({a_fs, a_bn, a_ls, a_tick, a_hs, a_vs} !== 6'b111011) begin
            bad++; $display("FAIL origin_flags got=%b want=111011", {a_fs, a_bn, a_ls, a_tick, a_hs, a_vs});
        end
        @(negedge clk);
        total++; if ({a_tick, a_hc} !== {1'b1, 11'd0}) begin bad++; $display("FAIL tick_period_hi got tick=%b h=%0d want 1,0", a_tick, a_hc); end
        @(negedge clk);
        total++; if ({a_tick, a_hc, a_fs} !== {1'b0, 11'd1, 1'b0}) begin bad++; $display("FAIL tick_period_lo got tick=%b h=%0d fs=%b want 0,1,0", a_tick, a_hc, a_fs); end
    endtask

    task automatic test_line;
        int hs_low = 0, bn_low = 0, first_hs = -1, err = 0, exp_h = 1;
        bit ok;
        for (int i = 0; i < 800; i++) begin
            wait_tick_a(ok);
            if (!ok) begin
                total++; bad++; $display("FAIL line_tick_timeout got no tick at pixel %0d want tick", i);
                return;
            end
            if (i < 799) begin
                if (a_hc !== 11'(exp_h) || a_vc !== 10'd0) err++;
                if (a_bn !== (exp_h < 640)) err++;
                if (a_hs !== !(exp_h >= 656 && exp_h <= 751)) err++;
                if (a_hs === 1'b0) begin
                    hs_low++;
                    if (first_hs < 0) first_hs = int'(a_hc);
                end
                if (a_bn === 1'b0) bn_low++;
                exp_h++;
            end else begin
                total++;
                if ({a_hc, a_vc, a_ls, a_bn} !== {11'd0, 10'd1, 1'b1, 1'b1}) begin
                    bad++; $display("FAIL line_wrap got h=%0d v=%0d ls=%b bn=%b want 0,1,1,1", a_hc, a_vc, a_ls, a_bn);
                end
            end
        end
        total++; if (hs_low != 96)    begin bad++; $display("FAIL hsync_len got=%0d want=96", hs_low); end
        total++; if (first_hs != 656) begin bad++; $display("FAIL hsync_start got=%0d want=656", first_hs); end
        total++; if (bn_low != 160)   begin bad++; $display("FAIL hblank_len got=%0d want=160", bn_low); end
        total++; if (err != 0)        begin bad++; $display("FAIL line_pixels got=%0d errors want=0", err); end
    endtask

    task automatic test_reset_mid;
        bit ok = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (a_hc === 11'd300 && a_tick === 1'b1) begin ok = 1'b1; break; end
        end
        total++; if (!ok || a_vc !== 10'd1) begin bad++; $display("FAIL midreset_reach got h=%0d v=%0d want 300,1", a_hc, a_vc); end
        rst_a = 1'b1;
        @(negedge clk);
        total++; if ({a_hc, a_vc} !== {11'd799, 10'd524}) begin bad++; $display("FAIL midreset_pos got h=%0d v=%0d want 799,524", a_hc, a_vc); end
        total++;
        if ({a_tick, a_hs, a_vs, a_bn, a_ls, a_fs, a_wa, a_wf} !== 8'b0110_0000) begin
            bad++; $display("FAIL midreset_flags got=%b want=01100000", {a_tick, a_hs, a_vs, a_bn, a_ls, a_fs, a_wa, a_wf});
        end
        rst_a = 1'b0;
        wait_tick_a(ok);
        @(negedge clk);
        total++;
        if (!ok || {a_fs, a_hc, a_vc} !== {1'b1, 11'd0, 10'd0}) begin
            bad++; $display("FAIL midreset_restart got fs=%b h=%0d v=%0d want 1,0,0", a_fs, a_hc, a_vc);
        end
    endtask

    task automatic test_frame_small;
        int err = 0, wa_cnt = 0, wf_cnt = 0, vs_cnt = 0, fs_cnt = 0, fs_pos0 = -1, fs_pos1 = -1;
        int mh, mv;
        logic wa_right = 1'b1, wa_below = 1'b1, wf_corner = 1'b0;
        logic [7:0] exp_f;
        rst_s = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if ({s_hc, s_vc, s_hs, s_vs, s_bn, s_ls, s_fs, s_wa, s_wf} !== {11'd23, 10'd17, 7'b1000000}) begin
            bad++; $display("FAIL small_reset got h=%0d v=%0d flags=%b want 23,17,1000000", s_hc, s_vc,
                            {s_hs, s_vs, s_bn, s_ls, s_fs, s_wa, s_wf});
        end
        rst_s = 1'b0;
        for (int n = 0; n < 2 * 432; n++) begin
            @(negedge clk);
            mh = n % 24;
            mv = (n / 24) % 18;
            exp_f = {1'b1, !(mh >= 18 && mh <= 20), (mv >= 14 && mv <= 15), (mh < 16 && mv < 12),
                     (mh == 0), (mh == 0 && mv == 0), (mh >= 4 && mh <= 9 && mv >= 3 && mv <= 7),
                     (mh == 4 && mv == 3)};
            if ({s_hc, s_vc} !== {11'(mh), 10'(mv)}) err++;
            if ({s_tick, s_hs, s_vs, s_bn, s_ls, s_fs, s_wa, s_wf} !== exp_f) err++;
            if (n < 432) begin
                if (s_wa === 1'b1) wa_cnt++;
                if (s_wf === 1'b1) wf_cnt++;
                if (s_vs === 1'b1) vs_cnt++;
            end
            if (s_fs === 1'b1) begin
                fs_cnt++;
                if (fs_pos0 < 0) fs_pos0 = n; else fs_pos1 = n;
            end
            if (s_hc === 11'd10 && s_vc === 10'd3) wa_right = s_wa;
            if (s_hc === 11'd4 && s_vc === 10'd8)  wa_below = s_wa;
            if (s_hc === 11'd4 && s_vc === 10'd3)  wf_corner = s_wf;
        end
        total++; if (err != 0)     begin bad++; $display("FAIL frame_pixels got=%0d errors want=0", err); end
        total++; if (wa_cnt != 30) begin bad++; $display("FAIL win_count got=%0d want=30", wa_cnt); end
        total++; if (wf_cnt != 1)  begin bad++; $display("FAIL win_first_count got=%0d want=1", wf_cnt); end
        total++; if (vs_cnt != 48) begin bad++; $display("FAIL vsync_len got=%0d want=48", vs_cnt); end
        total++;
        if (fs_cnt != 2 || fs_pos0 != 0 || fs_pos1 != 432) begin
            bad++; $display("FAIL frame_period got cnt=%0d at %0d,%0d want 2 at 0,432", fs_cnt, fs_pos0, fs_pos1);
        end
        total++; if (wa_right !== 1'b0)  begin bad++; $display("FAIL win_right_edge got=%b want=0", wa_right); end
        total++; if (wa_below !== 1'b0)  begin bad++; $display("FAIL win_bottom_edge got=%b want=0", wa_below); end
        total++; if (wf_corner !== 1'b1) begin bad++; $display("FAIL win_first_corner got=%b want=1", wf_corner); end
    endtask

`ifdef VGA_TEST_PATTERN_EN
    task automatic test_pattern;
        bit got_700 = 1'b0, got_128 = 1'b0;
        rst_p = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (p_pat !== 8'h00) begin bad++; $display("FAIL pattern_reset got=%h want=00", p_pat); end
        rst_p = 1'b0;
        for (int k = 0; k < 60000; k++) begin
            @(negedge clk);
            if (p_hc === 11'd128 && p_vc === 10'd0) begin
                total++; if (p_pat !== 8'h20) begin bad++; $display("FAIL pattern_128_0 got=%h want=20", p_pat); end
            end
            if (p_hc === 11'd700 && p_vc === 10'd0) begin
                got_700 = 1'b1;
                total++; if (p_pat !== 8'h00) begin bad++; $display("FAIL pattern_blank got=%h want=00", p_pat); end
            end
            if (p_hc === 11'd128 && p_vc === 10'd64) begin
                got_128 = 1'b1;
                total++; if (p_pat !== 8'h24) begin bad++; $display("FAIL pattern_128_64 got=%h want=24", p_pat); end
                break;
            end
        end
        total++; if (!(got_700 && got_128)) begin bad++; $display("FAIL pattern_reach got=%b%b want=11", got_700, got_128); end
    endtask
`endif

    initial begin
        rst_a = 1'b1;
        rst_s = 1'b1;
`ifdef VGA_TEST_PATTERN_EN
        rst_p = 1'b1;
`endif
        test_reset;
        test_line;
        test_reset_mid;
        test_frame_small;
`ifdef VGA_TEST_PATTERN_EN
        test_pattern;
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
